// File: rtl/rail_monitor_scheduler_pkg.sv
// Shared types and reset defaults for the rail monitor scheduler.
package rail_monitor_scheduler_pkg;

    typedef enum logic {
        RMS_IDLE = 1'b0,
        RMS_EMIT = 1'b1
    } rms_state_t;

    localparam logic [7:0] RAIL_LO_DEFAULT = 8'h00;
    localparam logic [7:0] RAIL_HI_DEFAULT = 8'hFF;

    // Index width that stays legal for a single-rail build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rail_monitor_scheduler_if.sv
// Telemetry valid/ready stream carrying one rail sample per word.
interface rail_monitor_scheduler_if #(
    parameter int NUMADCS = 5
) ();
    import rail_monitor_scheduler_pkg::*;

    localparam int CHAN_W = idx_width(NUMADCS);

    logic              m_valid;
    logic              m_ready;
    logic [CHAN_W-1:0] m_chan;
    logic [7:0]        m_data;
    logic              m_fault;

    modport master (output m_valid, m_chan, m_data, m_fault, input m_ready);
    modport slave  (input m_valid, m_chan, m_data, m_fault, output m_ready);

endinterface

// File: rtl/rail_monitor_scheduler_debounce.sv
// Per-rail fault debounce: the flag toggles only after DEBOUNCE consecutive
// captured sample sets disagree with it.
module rail_fault_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic sclk,
    input  logic rst,
    input  logic sample_en,
    input  logic oor,
    output logic fault
);

    logic [3:0] r_cnt;
    logic       r_fault;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (sample_en) begin
            if (oor != r_fault) begin
                if (r_cnt == 4'(DEBOUNCE - 1)) begin
                    r_fault <= ~r_fault;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign fault = r_fault;

endmodule

// File: rtl/rail_monitor_scheduler.sv
// Captures rail sample sets, serializes them onto the telemetry stream,
// and tracks window faults, dropped sets and sensor stalls.
//
//  state    | meaning
//  RMS_IDLE | waiting for a sample set strobe
//  RMS_EMIT | presenting snapshot word ch until the last word is accepted
module rail_monitor_scheduler
    import rail_monitor_scheduler_pkg::*;
#(
    parameter int NUMADCS      = 5,
    parameter int DEBOUNCE     = 4,
    parameter int STALE_CYCLES = 1_000_000
) (
    input  logic                           sclk,
    input  logic                           rst,
    input  logic [NUMADCS-1:0][7:0]        in_data,
    input  logic                           in_valid,
    input  logic                           cfg_we,
    input  logic [$clog2(2*NUMADCS)-1:0]   cfg_addr,
    input  logic [7:0]                     cfg_wdata,
    rail_monitor_scheduler_if.master       m_if,
    output logic [NUMADCS-1:0]             fault_vec,
    output logic                           overrun,
    output logic [7:0]                     overrun_cnt,
    output logic                           stale
);

    localparam int CHAN_W  = idx_width(NUMADCS);
    localparam int ADDR_W  = $clog2(2*NUMADCS);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    rms_state_t               r_state;
    rms_state_t               w_state_nxt;
    logic [CHAN_W-1:0]        r_ch;
    logic [CHAN_W-1:0]        w_ch_nxt;
    logic [NUMADCS-1:0][7:0]  r_snap;
    logic [NUMADCS-1:0][7:0]  r_lo;
    logic [NUMADCS-1:0][7:0]  r_hi;
    logic [NUMADCS-1:0]       w_oor;
    logic                     w_capture;
    logic                     w_drop;
    logic                     r_overrun;
    logic [7:0]               r_overrun_cnt;
    logic [STALE_W-1:0]       r_stale_cnt;

    assign w_capture = in_valid && (r_state == RMS_IDLE);
    assign w_drop    = in_valid && (r_state != RMS_IDLE);

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= RMS_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        m_if.m_valid = 1'b0;
        case (r_state)
            RMS_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = RMS_EMIT;
                    w_ch_nxt    = '0;
                end
            end
            RMS_EMIT: begin
                m_if.m_valid = 1'b1;
                if (m_if.m_ready) begin
                    if (r_ch == CHAN_W'(NUMADCS - 1)) begin
                        w_state_nxt = RMS_IDLE;
                    end else begin
                        w_ch_nxt = r_ch + CHAN_W'(1);
                    end
                end
            end
        endcase
    end

    assign m_if.m_chan  = r_ch;
    assign m_if.m_data  = r_snap[r_ch];
    assign m_if.m_fault = fault_vec[r_ch];

    // Thresholds are sampled before any same-cycle config write lands.
    for (genvar k = 0; k < NUMADCS; k++) begin : g_rail
        assign w_oor[k] = (in_data[k] < r_lo[k]) || (in_data[k] > r_hi[k]);

        rail_fault_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .sclk      (sclk),
            .rst       (rst),
            .sample_en (w_capture),
            .oor       (w_oor[k]),
            .fault     (fault_vec[k])
        );
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_snap        <= '0;
            r_lo          <= {NUMADCS{RAIL_LO_DEFAULT}};
            r_hi          <= {NUMADCS{RAIL_HI_DEFAULT}};
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
            r_stale_cnt   <= '0;
        end else begin
            if (w_capture) begin
                r_snap <= in_data;
            end
            r_overrun <= w_drop;
            if (w_drop && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (in_valid) begin
                r_stale_cnt <= '0;
            end else if (r_stale_cnt != STALE_W'(STALE_CYCLES)) begin
                r_stale_cnt <= r_stale_cnt + STALE_W'(1);
            end
            for (int k = 0; k < NUMADCS; k++) begin
                if (cfg_we && (cfg_addr == ADDR_W'(2*k))) begin
                    r_lo[k] <= cfg_wdata;
                end
                if (cfg_we && (cfg_addr == ADDR_W'(2*k + 1))) begin
                    r_hi[k] <= cfg_wdata;
                end
            end
        end
    end

    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;
    assign stale       = (r_stale_cnt >= STALE_W'(STALE_CYCLES));

endmodule

// File: tb/tb_rail_monitor_scheduler.sv
// Scoreboard bench for rail_monitor_scheduler: a cycle-level reference model
// predicts words and status, a negedge monitor compares them.
module tb_rail_monitor_scheduler;

    localparam int NA    = 5;
    localparam int DEB   = 4;
    localparam int STALE = 16;

    logic                 sclk      = 1'b0;
    logic                 rst       = 1'b1;
    logic [NA-1:0][7:0]   in_data   = '0;
    logic                 in_valid  = 1'b0;
    logic                 cfg_we    = 1'b0;
    logic [3:0]           cfg_addr  = '0;
    logic [7:0]           cfg_wdata = '0;
    logic [NA-1:0]        fault_vec;
    logic                 overrun;
    logic [7:0]           overrun_cnt;
    logic                 stale;

    rail_monitor_scheduler_if #(.NUMADCS(NA)) tel ();

    rail_monitor_scheduler #(
        .NUMADCS      (NA),
        .DEBOUNCE     (DEB),
        .STALE_CYCLES (STALE)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .m_if        (tel),
        .fault_vec   (fault_vec),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .stale       (stale)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int chan;
        int data;
        bit fault;
    } word_t;

    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    // Reference state: words still owed, thresholds, debounced flags and streaks.
    int pending = 0;
    int lo[NA];
    int hi[NA];
    bit mf[NA];
    int streak[NA];
    bit exp_ovr = 1'b0;
    int exp_ocnt = 0;
    int idle_cycles = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge sclk) begin
        bit hs;
        bit oor;
        if (rst) begin
            pending     = 0;
            sb.delete();
            exp_ovr     = 1'b0;
            exp_ocnt    = 0;
            idle_cycles = 0;
            for (int k = 0; k < NA; k++) begin
                lo[k] = 0;
                hi[k] = 255;
                mf[k] = 1'b0;
                streak[k] = 0;
            end
        end else begin
            hs      = (pending > 0) && tel.m_ready;
            exp_ovr = 1'b0;
            if (in_valid) begin
                if (pending == 0) begin
                    for (int k = 0; k < NA; k++) begin
                        oor = (int'(in_data[k]) < lo[k]) || (int'(in_data[k]) > hi[k]);
                        if (oor != mf[k]) begin
                            streak[k]++;
                            if (streak[k] == DEB) begin
                                mf[k] = !mf[k];
                                streak[k] = 0;
                            end
                        end else begin
                            streak[k] = 0;
                        end
                    end
                    for (int k = 0; k < NA; k++) begin
                        sb.push_back('{k, int'(in_data[k]), mf[k]});
                    end
                    pending = NA;
                end else begin
                    exp_ovr = 1'b1;
                    if (exp_ocnt < 255) exp_ocnt++;
                end
            end
            if (hs) pending--;
            if (cfg_we && (int'(cfg_addr) < 2*NA)) begin
                if (cfg_addr[0]) hi[int'(cfg_addr) / 2] = int'(cfg_wdata);
                else             lo[int'(cfg_addr) / 2] = int'(cfg_wdata);
            end
            if (in_valid) idle_cycles = 0;
            else if (idle_cycles < STALE) idle_cycles++;
        end
    end

    always @(negedge sclk) begin
        logic [NA-1:0] fv;
        if (mon_en) begin
            for (int k = 0; k < NA; k++) fv[k] = mf[k];
            chk("m_valid", tel.m_valid, pending > 0);
            chk("fault_vec", fault_vec, fv);
            chk("overrun", overrun, exp_ovr);
            chk("overrun_cnt", overrun_cnt, exp_ocnt);
            chk("stale", stale, idle_cycles >= STALE);
            if (tel.m_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: actual chan %0d data %0d, required no word (t=%0t)",
                             tel.m_chan, tel.m_data, $time);
                end else begin
                    chk("m_chan", tel.m_chan, sb[0].chan);
                    chk("m_data", tel.m_data, sb[0].data);
                    chk("m_fault", tel.m_fault, sb[0].fault);
                    if (tel.m_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_set(input logic [NA-1:0][7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] v);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = v;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        tel.m_ready = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic set, packing order and latency
        tel.m_ready = 1'b1;
        send_set({8'd10, 8'd20, 8'd30, 8'd40, 8'd50});
        chk("t1_first_chan", tel.m_chan, 0);
        chk("t1_first_data", tel.m_data, 50);
        idle(6);

        // Backpressure on word 2
        send_set({8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
        idle(2);
        tel.m_ready = 1'b0;
        idle(3);
        chk("t2_hold_chan", tel.m_chan, 2);
        chk("t2_hold_data", tel.m_data, 3);
        tel.m_ready = 1'b1;
        idle(6);

        // Debounce on rail 1 with hi[1]=100; out-of-range addresses ignored
        cfg(4'd3, 8'd100);
        cfg(4'd12, 8'd0);
        cfg(4'd15, 8'd0);
        for (int i = 0; i < 4; i++) begin
            send_set({8'd50, 8'd50, 8'd50, 8'd101, 8'd50});
            if (i == 2) chk("t3_not_set_after_3", fault_vec[1], 0);
            idle(6);
        end
        chk("t3_set_after_4", fault_vec[1], 1);
        for (int i = 0; i < 4; i++) begin
            send_set({8'd50, 8'd50, 8'd50, 8'd100, 8'd50});
            if (i == 2) chk("t3_not_clear_after_3", fault_vec[1], 1);
            idle(6);
        end
        chk("t3_clear_after_4", fault_vec[1], 0);
        for (int i = 0; i < 8; i++) begin
            send_set({8'd50, 8'd50, 8'd50, (i % 2 == 0) ? 8'd101 : 8'd90, 8'd50});
            chk("t3_alternating", fault_vec[1], 0);
            idle(6);
        end

        // Overrun while draining, then saturation
        tel.m_ready = 1'b0;
        send_set({8'd11, 8'd22, 8'd33, 8'd44, 8'd55});
        tick();
        send_set({8'd99, 8'd98, 8'd97, 8'd96, 8'd95});
        chk("t4_overrun_pulse", overrun, 1);
        chk("t4_overrun_cnt", overrun_cnt, 1);
        tel.m_ready = 1'b1;
        idle(7);
        tel.m_ready = 1'b0;
        send_set({8'd7, 8'd6, 8'd5, 8'd4, 8'd3});
        in_valid = 1'b1;
        idle(300);
        in_valid = 1'b0;
        chk("t4_overrun_sat", overrun_cnt, 8'hFF);
        tel.m_ready = 1'b1;
        idle(7);

        // Stale after STALE idle cycles, cleared by the next strobe
        idle(8);
        chk("t5_not_stale_15", stale, 0);
        tick();
        chk("t5_stale_16", stale, 1);
        send_set({8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
        chk("t5_stale_clear", stale, 0);
        idle(6);

        // Reset mid-emit with a fault latched and a custom threshold
        cfg(4'd0, 8'd200);
        for (int i = 0; i < 4; i++) begin
            send_set({8'd10, 8'd10, 8'd10, 8'd10, 8'd10});
            idle(6);
        end
        chk("t6_fault0_set", fault_vec[0], 1);
        send_set({8'd60, 8'd61, 8'd62, 8'd63, 8'd64});
        idle(3);
        chk("t6_at_word3", tel.m_chan, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid_dropped", tel.m_valid, 0);
        chk("t6_fault_cleared", fault_vec, 0);
        for (int i = 0; i < 4; i++) begin
            send_set({8'd10, 8'd10, 8'd10, 8'd255, 8'd0});
            if (i == 0) chk("t6_restart_chan0", tel.m_chan, 0);
            idle(6);
        end
        chk("t6_default_thresholds", fault_vec, 0);

        // Randomized traffic, backpressure, config and one reset
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < NA; k++) in_data[k] = 8'($urandom_range(0, 255));
            tel.m_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_addr  = 4'($urandom_range(0, 15));
            cfg_wdata = 8'($urandom_range(0, 255));
            rst       = (i == 250);
            tick();
        end
        in_valid    = 1'b0;
        cfg_we      = 1'b0;
        rst         = 1'b0;
        tel.m_ready = 1'b1;
        idle(10);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
